// File: rtl/xor_nn_pkg.sv
// Shared definitions for the XOR neural-net handshake sequencer: state encoding,
// vector count, LFSR constants and the reference XOR function.
package xor_nn_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_SETUP   = 3'd1;
    localparam state_t S_REQ     = 3'd2;
    localparam state_t S_CAPTURE = 3'd3;
    localparam state_t S_RELEASE = 3'd4;
    localparam state_t S_NEXT    = 3'd5;
    localparam state_t S_REPORT  = 3'd6;

    localparam int unsigned NUM_VECTORS = 4;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left with feedback into bit 0
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic expected_xor(input logic [1:0] idx);
        return idx[1] ^ idx[0];
    endfunction

endpackage

// File: rtl/xor_seq_timer.sv
// Loadable down-counter shared by the input-settle pause and the handshake timeouts;
// o_expired is high while the count sits at zero.
module xor_seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/xor_nn_sequencer.sv
// Drives all four XOR input vectors through the NN core's four-phase start/done handshake
// and scores the answers. Define XOR_SEQ_LFSR_EN to rotate the vector order from an LFSR offset.
module xor_nn_sequencer
    import xor_nn_pkg::*;
#(
    parameter int unsigned PAUSE_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             loop,
    output logic             nn_x1,
    output logic             nn_x2,
    output logic             nn_start,
    input  logic             nn_y,
    input  logic             nn_done,
    output logic             busy,
    output logic [3:0]       result,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             timeout_err,
    output logic             sweep_done
);

    localparam int unsigned MAX_CYC = (PAUSE_CYCLES > TIMEOUT_CYCLES) ? PAUSE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] PAUSE_LD = TMR_W'(PAUSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LD   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       LAST_VEC = 2'(NUM_VECTORS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       r_vcnt;
    logic             r_run_d;
    logic             r_err;
    logic             r_ycap;
    logic [3:0]       r_result;
    logic             r_pass;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_timeout;
    logic             w_run_rise;
    logic [1:0]       w_start_idx;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_exp;

`ifdef XOR_SEQ_LFSR_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
        end
    end

    assign w_start_idx = r_lfsr[1:0];
`else
    assign w_start_idx = 2'b00;
`endif

    assign w_run_rise = run & ~r_run_d;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_run_rise) w_state_nxt = S_SETUP;
            S_SETUP:   if (w_tmr_exp) w_state_nxt = S_REQ;
            S_REQ: begin
                if (nn_done)        w_state_nxt = S_CAPTURE;
                else if (w_tmr_exp) w_state_nxt = S_RELEASE;
            end
            S_CAPTURE: w_state_nxt = S_RELEASE;
            S_RELEASE: if (!nn_done || w_tmr_exp) w_state_nxt = S_NEXT;
            S_NEXT:    w_state_nxt = (r_vcnt == LAST_VEC) ? S_REPORT : S_SETUP;
            S_REPORT:  w_state_nxt = loop ? S_SETUP : S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Every state change reloads the timer, so each phase counts from its own entry.
    assign w_tmr_load = (w_state_nxt != r_state);
    assign w_tmr_val  = (w_state_nxt == S_SETUP) ? PAUSE_LD : TMO_LD;

    xor_seq_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (~w_tmr_load),
        .o_expired  (w_tmr_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_vcnt     <= '0;
            r_run_d    <= 1'b0;
            r_err      <= 1'b0;
            r_ycap     <= 1'b0;
            r_result   <= '0;
            r_pass     <= 1'b0;
            r_fail_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_run_d <= run;
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_run_rise) begin
                        r_idx  <= w_start_idx;
                        r_vcnt <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_REQ: begin
                    // y is taken in the same cycle done is first seen
                    if (nn_done) begin
                        r_ycap <= nn_y;
                    end else if (w_tmr_exp) begin
                        r_timeout       <= 1'b1;
                        r_err           <= 1'b1;
                        r_result[r_idx] <= 1'b0;
                        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    r_result[r_idx] <= r_ycap;
                    if (r_ycap != expected_xor(r_idx)) begin
                        r_err <= 1'b1;
                        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (nn_done && w_tmr_exp) begin
                        r_timeout <= 1'b1;
                        r_err     <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_vcnt != LAST_VEC) begin
                        r_idx  <= r_idx + 2'd1;
                        r_vcnt <= r_vcnt + 2'd1;
                    end
                end
                S_REPORT: begin
                    r_pass <= ~r_err;
                    if (loop) begin
                        r_idx  <= w_start_idx;
                        r_vcnt <= '0;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign nn_x1       = r_idx[1];
    assign nn_x2       = r_idx[0];
    assign nn_start    = (r_state == S_REQ);
    assign busy        = (r_state != S_IDLE);
    assign sweep_done  = (r_state == S_REPORT);
    assign result      = r_result;
    assign pass        = r_pass;
    assign fail_cnt    = r_fail_cnt;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_xor_nn_sequencer.sv
// Directed bench for xor_nn_sequencer with a behavioural NN core (done 3 cycles after start).
module tb_xor_nn_sequencer;

    localparam int PAUSE   = 16;
    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       loop = 1'b0;
    logic       nn_x1, nn_x2, nn_start, busy, pass, timeout_err, sweep_done;
    logic       nn_y, nn_done;
    logic [3:0] result;
    logic [7:0] fail_cnt;

    always #5 clk = ~clk;

    xor_nn_sequencer #(.PAUSE_CYCLES(PAUSE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .loop(loop),
        .nn_x1(nn_x1), .nn_x2(nn_x2), .nn_start(nn_start),
        .nn_y(nn_y), .nn_done(nn_done),
        .busy(busy), .result(result), .pass(pass), .fail_cnt(fail_cnt),
        .timeout_err(timeout_err), .sweep_done(sweep_done)
    );

    logic [18:0] all_out;
    assign all_out = {nn_x1, nn_x2, nn_start, busy, result, pass, fail_cnt, timeout_err, sweep_done};

    // NN core model and monitors
    int         ymode = 0;
    bit         hang_en = 0;
    logic [1:0] hang_vec = 2'b00;
    int         m_cnt = 0, hi_cur = 0, stab = 0, sd_cnt = 0, xviol = 0;
    logic       prev_start = 1'b0;
    logic [1:0] prev_x = 2'b00;
    logic [1:0] ord_q[$];
    int         hi_q[$];
    int         stab_q[$];

    function automatic logic model_y(input logic [1:0] x);
        case (ymode)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ~(x[1] ^ x[0]);
            default: return x[1] ^ x[0];
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; hi_cur = 0; stab = 0;
            prev_start = 1'b0; prev_x = 2'b00;
            nn_done <= 1'b0; nn_y <= 1'b0;
        end else begin
            if ({nn_x1, nn_x2} != prev_x) stab = 0; else stab++;
            prev_x = {nn_x1, nn_x2};
            if (nn_start && !prev_start) begin
                ord_q.push_back({nn_x1, nn_x2});
                stab_q.push_back(stab);
            end
            if (nn_start && prev_start && stab == 0) xviol++;
            if (nn_start) begin
                hi_cur++;
                if (!(hang_en && {nn_x1, nn_x2} == hang_vec)) begin
                    if (m_cnt >= 2) begin
                        nn_done <= 1'b1;
                        nn_y    <= model_y({nn_x1, nn_x2});
                    end
                    m_cnt++;
                end
            end else begin
                if (hi_cur != 0) hi_q.push_back(hi_cur);
                hi_cur = 0; m_cnt = 0;
                nn_done <= 1'b0;
            end
            prev_start = nn_start;
            if (sweep_done) sd_cnt++;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        repeat (2) @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_sd(input int target, input int budget, input string nm);
        int n = 0;
        while (sd_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(sd_cnt >= target), 32'd1);
    endtask

    typedef struct {
        string      name;
        int         ymode;
        bit         hang;
        logic [1:0] hvec;
        logic [3:0] res;
        logic       pass;
        int         fail;
        logic       tmo;
        int         hi;
    } vec_t;

    vec_t tbl[5];

    initial begin : main
        int sb, ob, hb, stb, xb, mx, mn;
        logic [7:0] ord_w, exp_w;
        logic [1:0] off;

        tbl[0] = '{"ideal",    0, 1'b0, 2'b00, 4'b0110, 1'b1, 0, 1'b0, 4};
        tbl[1] = '{"stuck1",   1, 1'b0, 2'b00, 4'b1111, 1'b0, 2, 1'b0, 4};
        tbl[2] = '{"stuck0",   2, 1'b0, 2'b00, 4'b0000, 1'b0, 2, 1'b0, 4};
        tbl[3] = '{"inverted", 3, 1'b0, 2'b00, 4'b1001, 1'b0, 4, 1'b0, 4};
        tbl[4] = '{"hang10",   0, 1'b1, 2'b10, 4'b0010, 1'b0, 1, 1'b1, TIMEOUT};

        rst = 1'b1;
        #12;
        chk("reset_outputs", 32'(all_out), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            ymode = tbl[i].ymode; hang_en = tbl[i].hang; hang_vec = tbl[i].hvec;
            do_reset();
            sb = sd_cnt; ob = ord_q.size(); hb = hi_q.size(); stb = stab_q.size(); xb = xviol;
            @(negedge clk);
            run = 1'b1;
            wait_sd(sb + 1, 3000, {tbl[i].name, "_sweep_seen"});
            repeat (40) @(negedge clk);
            run = 1'b0;
            repeat (5) @(negedge clk);
            chk({tbl[i].name, "_result"},  32'(result),      32'(tbl[i].res));
            chk({tbl[i].name, "_pass"},    32'(pass),        32'(tbl[i].pass));
            chk({tbl[i].name, "_failcnt"}, 32'(fail_cnt),    32'(tbl[i].fail));
            chk({tbl[i].name, "_timeout"}, 32'(timeout_err), 32'(tbl[i].tmo));
            chk({tbl[i].name, "_busy_end"}, 32'(busy), 32'd0);
            chk({tbl[i].name, "_one_sweep"}, 32'(sd_cnt - sb), 32'd1);
            chk({tbl[i].name, "_n_vectors"}, 32'(ord_q.size() - ob), 32'd4);
            chk({tbl[i].name, "_x_stable"}, 32'(xviol - xb), 32'd0);
            if (ord_q.size() - ob >= 4) begin
                ord_w = {ord_q[ob], ord_q[ob+1], ord_q[ob+2], ord_q[ob+3]};
                chk({tbl[i].name, "_order"}, 32'(ord_w), 32'h1B);
            end
            mx = 0;
            for (int k = hb; k < hi_q.size(); k++) if (hi_q[k] > mx) mx = hi_q[k];
            chk({tbl[i].name, "_start_len"}, 32'(mx), 32'(tbl[i].hi));
            mn = 1 << 30;
            for (int k = stb; k < stab_q.size(); k++) if (stab_q[k] < mn) mn = stab_q[k];
            chk({tbl[i].name, "_settle"}, 32'(mn >= PAUSE), 32'd1);
        end

        // loop for three sweeps with busy held throughout
        ymode = 0; hang_en = 0;
        do_reset();
        sb = sd_cnt;
        loop = 1'b1;
        pulse_run();
        begin
            int n = 0, lows = 0;
            while (!busy && n < 10) begin @(negedge clk); n++; end
            chk("loop_busy_rise", 32'(busy), 32'd1);
            n = 0;
            while (sd_cnt < sb + 2 && n < 1000) begin
                @(negedge clk); n++;
                if (!busy) lows++;
            end
            loop = 1'b0;
            while (sd_cnt < sb + 3 && n < 1500) begin
                if (!busy) lows++;
                @(negedge clk); n++;
            end
            chk("loop_busy_gaps", 32'(lows), 32'd0);
        end
        repeat (300) @(negedge clk);
        chk("loop_sweeps", 32'(sd_cnt - sb), 32'd3);
        chk("loop_busy_end", 32'(busy), 32'd0);
        chk("loop_failcnt", 32'(fail_cnt), 32'd0);
        chk("loop_pass", 32'(pass), 32'd1);
        chk("loop_result", 32'(result), 32'h6);

        // reset during REQ of vector 01 after a mismatch on vector 00
        ymode = 1;
        do_reset();
        pulse_run();
        begin
            int n = 0;
            while (!(nn_start && {nn_x1, nn_x2} == 2'b01) && n < 600) begin @(negedge clk); n++; end
            chk("rst_reached_req01", 32'(nn_start && {nn_x1, nn_x2} == 2'b01), 32'd1);
        end
        chk("rst_pre_failcnt", 32'(fail_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_start_drop", 32'(nn_start), 32'd0);
        chk("rst_all_zero", 32'(all_out), 32'd0);
        sb = sd_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ymode = 0;
        repeat (20) @(negedge clk);
        chk("rst_no_sweep_done", 32'(sd_cnt - sb), 32'd0);
        ob = ord_q.size();
        pulse_run();
        wait_sd(sb + 1, 600, "rst_restart_sweep");
        chk("rst_restart_first_vec", 32'(ord_q.size() > ob ? ord_q[ob] : 2'b11), 32'd0);
        chk("rst_restart_result", 32'(result), 32'h6);
        chk("rst_restart_pass", 32'(pass), 32'd1);

`ifdef XOR_SEQ_LFSR_EN
        begin
            int distinct = 0;
            logic [1:0] first_off = 2'b00;
            do_reset();
            for (int s = 0; s < 16; s++) begin
                sb = sd_cnt; ob = ord_q.size();
                repeat (s * 3 + 1) @(negedge clk);
                pulse_run();
                wait_sd(sb + 1, 600, "lfsr_sweep");
                chk("lfsr_n_vectors", 32'(ord_q.size() - ob), 32'd4);
                if (ord_q.size() - ob >= 4) begin
                    off = ord_q[ob];
                    ord_w = {ord_q[ob], ord_q[ob+1], ord_q[ob+2], ord_q[ob+3]};
                    exp_w = {off, off + 2'd1, off + 2'd2, off + 2'd3};
                    chk("lfsr_rotation", 32'(ord_w), 32'(exp_w));
                    if (s == 0) first_off = off;
                    else if (off != first_off) distinct++;
                end
                chk("lfsr_result", 32'(result), 32'h6);
            end
            chk("lfsr_offsets_vary", 32'(distinct > 0), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/xor_nn_sequencer.md
Name: xor_nn_sequencer

Overview:
- Initiator-side driver for the XOR neural-net core's start/x1/x2 -> y_out/done handshake.
- Replaces the MCU pin-wiggling: on command, applies all four input vectors (00, 01, 10, 11) in turn and captures each y_out.
- Compares each capture against the expected XOR and reports a 4-bit result map, pass flag, error count and timeout status.
- Sits in the top level between the MKR header pins (run/status) and the xor_nn instance, on the same memory-domain clock.

Parameters:
- PAUSE_CYCLES, 16, idle cycles with x1/x2 stable before start is raised (input settle time); minimum 1.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for done to rise, or to fall after release; minimum 2.
- CNT_W, 8, width of fail_cnt; saturates at all-ones.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  rising edge starts one sweep; ignored while busy.
- loop  in  1  sampled at the end of each sweep; if 1, the next sweep starts immediately.
- nn_x1  out  1  x1 to the NN core.
- nn_x2  out  1  x2 to the NN core.
- nn_start  out  1  active-high request level to the NN core (the top-level inverts it if required).
- nn_y  in  1  y_out from the NN core.
- nn_done  in  1  done from the NN core.
- busy  out  1  high from sweep start until sweep_done.
- result  out  4  bit i = captured y for vector i, where i = {x1,x2}.
- pass  out  1  1 when the last completed sweep had no mismatch and no timeout.
- fail_cnt  out  CNT_W  count of mismatched or timed-out vectors since reset, saturating.
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst.
- sweep_done  out  1  one-cycle pulse at the end of each sweep.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, vector index 0, run edge detector cleared.
- run edge detection: a registered copy of run; a rising edge is accepted only in IDLE.
- Handshake (four-phase):
  - start rises only after x1/x2 have been stable for PAUSE_CYCLES.
  - x1/x2 stay stable while start=1.
  - nn_y is sampled in the first cycle nn_done=1 is seen.
  - start then falls; the next vector waits until nn_done=0.
- State machine:
  - IDLE: on a run edge, idx<=0 (LFSR variant: idx<=lfsr[1:0]), clear the sweep-local error flag, busy<=1 -> SETUP.
  - SETUP: drive nn_x1/nn_x2=idx; count PAUSE_CYCLES -> REQ.
  - REQ: nn_start=1; timer loads TIMEOUT_CYCLES.
    - nn_done=1 -> CAPTURE.
    - Timer expiry -> set timeout_err and the error flag, result[idx]<=0, fail_cnt++ -> RELEASE.
  - CAPTURE (1 cycle): result[idx]<=nn_y; if nn_y != (idx[1]^idx[0]), set the error flag and fail_cnt++ -> RELEASE.
  - RELEASE: nn_start=0; timer reloads.
    - nn_done=0 -> NEXT.
    - Expiry -> timeout_err<=1, error flag set -> NEXT. fail_cnt is not incremented a second time for the same vector.
  - NEXT:
    - If 4 vectors are done -> REPORT.
    - Otherwise advance idx (wraps 11->00 in sequential mode) -> SETUP.
  - REPORT (1 cycle): pass<=~error flag, sweep_done=1.
    - If loop=1, restart as from IDLE with busy held at 1.
    - Otherwise busy<=0 -> IDLE.
- nn_done already high on entry to REQ is accepted immediately: capture occurs 1 cycle after start rises.
- Minimum per-vector latency: PAUSE_CYCLES + 1 (REQ) + 1 (CAPTURE) + 1 (RELEASE) + 1 (NEXT), assuming an immediate done response.
- result and pass hold their values until overwritten by the next sweep; result bits are updated per vector mid-sweep.
- Reset mid-sweep: immediate abort. nn_start drops asynchronously to 0, and no sweep_done is produced.
- run asserted continuously produces only one sweep unless loop=1.

Optional Feature:
- Macro XOR_SEQ_LFSR_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances every clock.
  - Vector order is a starting offset lfsr[1:0], then +1 mod 4. All four vectors are still covered exactly once, in rotated order.
- Undefined: fixed order 00, 01, 10, 11; no LFSR logic is synthesized.

Decomposition:
- Package xor_nn_pkg:
  - state encoding (IDLE, SETUP, REQ, CAPTURE, RELEASE, NEXT, REPORT);
  - NUM_VECTORS=4;
  - LFSR seed/taps constants;
  - function expected_xor(idx).
- Sub-module xor_seq_timer: loadable down-counter with load/enable/expired outputs, shared by the PAUSE and TIMEOUT phases; width from $clog2 of the larger parameter.

Test Plan:
- Ideal NN model (done 3 cycles after start, y=x1^x2), run pulse -> result=4'b0110, pass=1, fail_cnt=0, one sweep_done, busy low afterwards.
- Model with y stuck at 1 -> result=4'b1111, pass=0, fail_cnt=2.
- Model never raises done for vector 10 -> timeout_err=1 after 1024 cycles in REQ, result[2]=0, fail_cnt=1, sweep completes, pass=0.
- loop=1 for 3 sweeps, then loop=0 -> exactly 3 sweep_done pulses, busy continuous across them, fail_cnt=0.
- rst asserted during REQ of vector 01 -> nn_start=0 immediately, all outputs 0, a new run edge restarts at vector 00.
- With XOR_SEQ_LFSR_EN, 16 sweeps -> each sweep covers all four vectors once, start offsets are not all equal, result=4'b0110 each time.
